// File: rtl/pow3_gen_if.sv
// pow3_gen_if: request/result handshake bundle for the power-of-three generator.
// The master side supplies exponents and consumes results; the slave side is
// the generator itself.
interface pow3_gen_if #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [EXP_W-1:0] k;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pow;
    logic             overflow;

    modport master (
        output in_valid,
        output k,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  pow,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  k,
        input  out_ready,
        output in_ready,
        output out_valid,
        output pow,
        output overflow
    );
endinterface

// File: rtl/pow3_gen.sv
// pow3_gen: iterative 3^k generator. One multiply-by-three per clock computed
// as acc + (acc << 1); exponents whose power does not fit in WIDTH bits stop
// early with overflow=1 and pow=0.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | waiting for an exponent
// RUN   | multiplying, one x3 step per clock
// DONE  | presenting pow/overflow until out_ready
module pow3_gen #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 5,
    parameter int KMAX  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    pow3_gen_if.slave  bus
);

    // Largest k with 3^k <= 2^w - 1, used only to catch an inconsistent KMAX.
    function automatic int calc_kmax(input int w);
        logic [127:0] v;
        logic [127:0] lim;
        int           m;
        v   = 128'd1;
        lim = (128'd1 << w) - 128'd1;
        m   = 0;
        while ((v * 128'd3) <= lim) begin
            v = v * 128'd3;
            m = m + 1;
        end
        return m;
    endfunction

    localparam int KMAX_CALC = calc_kmax(WIDTH);

    if (KMAX != KMAX_CALC) begin : g_kmax_mismatch
        $error("pow3_gen: KMAX does not match WIDTH");
    end

    localparam int AW = WIDTH + 2;
    localparam logic [AW-1:0] MAX_VAL = {2'b00, {WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pow_q, pow_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic [AW-1:0]    t;
    logic             accept;

    // Ready is combinational so a DONE result can hand off and accept in one edge.
    assign bus.in_ready = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.pow       = pow_q;
    assign bus.overflow  = ovf_q;

    // State and datapath registers; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            pow_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pow_q       <= pow_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and next-output logic; an accept overrides the per-state choice.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        pow_d       = pow_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        // acc only ever holds values that fit in WIDTH bits, so t cannot wrap.
        t           = acc_q + (acc_q << 1);

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (t > MAX_VAL) begin
                    state_d     = DONE;
                    pow_d       = '0;
                    ovf_d       = 1'b1;
                    out_valid_d = 1'b1;
                end else if (cnt_q == EXP_W'(1)) begin
                    state_d     = DONE;
                    pow_d       = t[WIDTH-1:0];
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    acc_d = t;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase

        if (accept) begin
            acc_d = AW'(1);
            cnt_d = bus.k;
            if (bus.k == '0) begin
                state_d     = DONE;
                pow_d       = WIDTH'(1);
                ovf_d       = 1'b0;
                out_valid_d = 1'b1;
            end else begin
                state_d     = RUN;
                out_valid_d = 1'b0;
            end
        end
    end

endmodule

// File: doc/pow3_gen.md
# pow3_gen

Iterative power-of-three generator: accepts an exponent k over a valid/ready handshake and returns 3^k as a WIDTH-bit unsigned value, or flags overflow when 3^k does not fit. It is the generating counterpart of the power-of-three checker. It supplies reference values and stimulus to that checker, and to any logic that needs exact powers of three without a lookup table. Each multiply step is computed as acc + (acc << 1), one step per clock.

## Interface
- WIDTH, 32, result width in bits.
- EXP_W, 5, exponent width in bits.
- KMAX, 20, largest k with 3^k ≤ 2^WIDTH−1. Must be consistent with WIDTH; 20 for WIDTH=32.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  k is valid.
- in_ready  output  1  block can accept k.
- k  input  EXP_W  exponent, unsigned.
- out_valid  output  1  pow and overflow are valid.
- out_ready  input  1  consumer accepts the result.
- pow  output  WIDTH  3^k; 0 when overflow=1.
- overflow  output  1  3^k > 2^WIDTH−1.

## Operation
- States:
  - IDLE: waiting for an exponent.
  - RUN: multiplying.
  - DONE: presenting the result.
- Internal state: acc (WIDTH+2 bits) and cnt (EXP_W bits).
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational from state and out_ready.
- Accept: on in_valid & in_ready, acc←1 and cnt←k.
  - k==0: next state DONE, with pow←1 and overflow←0.
  - k>0: next state RUN.
- RUN, every cycle:
  - t = acc + (acc<<1), computed at WIDTH+2 bits.
  - cnt←cnt−1.
  - If t > 2^WIDTH−1: go to DONE with overflow←1 and pow←0 (early termination).
  - Else if cnt==1: go to DONE with pow←t[WIDTH−1:0] and overflow←0.
  - Else: acc←t and stay in RUN.
- In RUN, in_valid is ignored; in_ready=0.
- DONE:
  - out_valid=1.
  - pow and overflow are held stable while out_ready=0.
  - On out_ready alone: go to IDLE and deassert out_valid.
  - On out_ready & in_valid in the same cycle: hand off and accept the new k at the same edge. The next state follows the accept rule (DONE again for k==0, else RUN).
- pow, overflow and out_valid are registered outputs.
- Arithmetic: acc never exceeds 3·(2^WIDTH−1), so WIDTH+2 bits suffice. No wrap-around is permitted; overflow is detected before truncation.

## Timing
- Reset, while rst_n=0 and after release:
  - state=IDLE.
  - out_valid=0, pow=0, overflow=0.
  - in_ready=1; inputs are ignored while rst_n=0.
- Latency: let E0 be the accept edge. out_valid rises at edge E0+L, where L = min(k, KMAX+1).
  - k=0: out_valid is high in the cycle directly after E0.
  - Overflowing exponents (k > KMAX) all finish at E0+KMAX+1 (E0+21 for WIDTH=32).
- Throughput: one result per L+1 cycles with out_ready held high. The DONE→accept overlap removes the IDLE bubble.
- Backpressure: the result is held indefinitely. No new k is accepted until out_ready=1.
- Reset mid-operation: the asynchronous assert aborts RUN or DONE immediately. Outputs go to their reset values and the aborted result is never presented.
- out_valid, pow and overflow must not change in the same cycle as an input change. They are registered only.

## Test plan
- Basic values: k=0, 1, 2, 5 each with out_ready=1 → pow=1, 3, 9, 243; overflow=0. out_valid rises at edges E0+0, +1, +2, +5.
- Largest in-range exponent: k=20 → pow=3486784401 (0xCFD41B91), overflow=0, out_valid at E0+20.
- Overflow: k=21 → overflow=1, pow=0 at E0+21. k=31 → overflow=1, pow=0, also at E0+21 (early termination), and in_ready=0 throughout RUN.
- Backpressure: k=3 with out_ready=0 for 6 cycles after out_valid → pow=27 stable, in_valid with k=4 is not accepted. Then out_ready=1 → handoff, k=4 accepted on the same edge, pow=81 four cycles later.
- Back-to-back: k=2, k=0, k=3 streamed with in_valid and out_ready high → results 9, 1, 27 in order, with no idle cycle between handoff and accept.
- Reset: assert rst_n=0 for one cycle at E0+7 of a k=15 run → out_valid, pow and overflow drop to 0 asynchronously and in_ready=1. The next k=1 returns pow=3 at E0'+1.
